// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, default sizes and parity helper for regfile_mp.
// REGFILE_PARITY_EN adds one even-parity bit to each stored word.
package regfile_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH = 32;
  localparam int MAX_W = 1024;
`ifdef REGFILE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  function automatic logic parity(input logic [MAX_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port with write bypass, zero-entry and range checks.
// REGFILE_PARITY_EN adds a registered parity-mismatch flag.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int SW = DATA_W + PAR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SW-1:0]     mem [DEPTH],
`ifdef REGFILE_PARITY_EN
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] data
);
  logic in_range, zero, byp;
  logic [SW-1:0] entry;
  logic [DATA_W-1:0] nxt;
  always_comb begin
    in_range = 32'(addr) < DEPTH;
    zero = ZERO_REG != 0 && addr == '0;
    byp = wr_en && wr_addr == addr;
    entry = in_range ? mem[addr] : '0;
    nxt = (!in_range || zero) ? '0 : byp ? wr_data : entry[DATA_W-1:0];
  end
  always_ff @(posedge clk)
    if (reset) data <= '0;
    else if (en) data <= nxt;
`ifdef REGFILE_PARITY_EN
  logic perr;
  assign perr = in_range && !zero && !byp && (parity(MAX_W'(entry[DATA_W-1:0])) != entry[DATA_W]);
  always_ff @(posedge clk)
    if (reset) par_err <= 1'b0;
    else par_err <= en && perr;
`endif
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write bypass and a one-entry-per-cycle clear sequencer.
// REGFILE_PARITY_EN stores a parity bit per entry and reports mismatches on par_err.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clear_req,
`ifdef REGFILE_PARITY_EN
  output logic [NUM_RD-1:0]        par_err,
`endif
  output logic                     busy
);
  localparam int SW = DATA_W + PAR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] wr_word;
  logic accept, we;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == CLEAR) begin
      state_n = cnt == LAST ? READY : CLEAR;
      cnt_n = cnt == LAST ? '0 : cnt + 1'b1;
    end else if (clear_req) begin
      state_n = CLEAR;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  assign busy = state == CLEAR;
  assign accept = !busy && rd_en;
  // a clear request in the same cycle wins over the write
  assign we = !busy && wr_en && !clear_req && 32'(wr_addr) < DEPTH && !(ZERO_REG != 0 && wr_addr == '0);
`ifdef REGFILE_PARITY_EN
  assign wr_word = {parity(MAX_W'(wr_data)), wr_data};
`else
  assign wr_word = wr_data;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      if (busy) mem[cnt] <= '0;
      else if (we) mem[wr_addr] <= wr_word;
    end
  always_ff @(posedge clk)
    if (reset) rd_valid <= 1'b0;
    else rd_valid <= accept;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    regfile_rd_port #(
      .DATA_W(DATA_W),
      .DEPTH(DEPTH),
      .ZERO_REG(ZERO_REG),
      .ADDR_W(ADDR_W),
      .SW(SW)
    ) u_port (
      .clk(clk),
      .reset(reset),
      .en(accept),
      .addr(rd_addr[k*ADDR_W +: ADDR_W]),
      .wr_en(we),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .mem(mem),
`ifdef REGFILE_PARITY_EN
      .par_err(par_err[k]),
`endif
      .data(rd_data[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp with a per-cycle reference model.
// REGFILE_PARITY_EN enables the parity-injection test.
module tb_regfile_mp;
  logic clk = 0;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic reset, rd_en, wr_en, clear_req, busy, rd_valid;
  logic [9:0] rd_addr;
  logic [127:0] rd_data;
  logic [4:0] wr_addr;
  logic [63:0] wr_data;
  logic [1:0] par_err;
  logic b_reset, b_rd_en, b_wr_en, b_clear_req, b_busy, b_rd_valid;
  logic [14:0] b_rd_addr;
  logic [191:0] b_rd_data;
  logic [4:0] b_wr_addr;
  logic [63:0] b_wr_data;
  logic [2:0] b_par_err;
  regfile_mp #(.DATA_W(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef REGFILE_PARITY_EN
    .par_err(par_err),
`endif
    .clear_req(clear_req), .busy(busy)
  );
  regfile_mp #(.DATA_W(64), .DEPTH(20), .NUM_RD(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(b_reset), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
`ifdef REGFILE_PARITY_EN
    .par_err(b_par_err),
`endif
    .clear_req(b_clear_req), .busy(b_busy)
  );
`ifndef REGFILE_PARITY_EN
  assign par_err = '0;
  assign b_par_err = '0;
`endif
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // reference model: contents as an array, the clear as a countdown of busy cycles
  logic [63:0] m [32];
  logic [63:0] e_data [2];
  logic [1:0] e_par;
  logic e_valid;
  int left;
  bit live = 0, flip_active = 0;
  logic w;
  int a;
  always @(posedge clk) begin
    if (reset) begin
      live = 1;
      left = 32;
      e_valid = 0;
      e_par = 0;
      e_data[0] = 0;
      e_data[1] = 0;
      foreach (m[i]) m[i] = 0;
    end else if (left > 0) begin
      left--;
      e_valid = 0;
      e_par = 0;
    end else begin
      w = wr_en && !clear_req && wr_addr != 0;
      e_valid = rd_en;
      e_par = 0;
      if (rd_en)
        for (int k = 0; k < 2; k++) begin
          a = int'(rd_addr[k*5 +: 5]);
          e_data[k] = a == 0 ? 64'd0 : (w && int'(wr_addr) == a) ? wr_data : m[a];
          e_par[k] = a == 10 && flip_active && !(w && wr_addr == 5'd10);
        end
      if (clear_req) begin
        left = 32;
        foreach (m[i]) m[i] = 0;
      end else if (w) m[wr_addr] = wr_data;
    end
  end
  always @(negedge clk)
    if (live) begin
      check("busy", {255'd0, busy}, {255'd0, left > 0});
      check("rd_valid", {255'd0, rd_valid}, {255'd0, e_valid});
      check("rd_data0", {192'd0, rd_data[63:0]}, {192'd0, e_data[0]});
      check("rd_data1", {192'd0, rd_data[127:64]}, {192'd0, e_data[1]});
      check("par_err", {254'd0, par_err}, {254'd0, e_par});
    end
  int n;
  initial begin
    reset = 1; rd_en = 0; wr_en = 0; clear_req = 0; rd_addr = 0; wr_addr = 0; wr_data = 0;
    b_reset = 1; b_rd_en = 0; b_wr_en = 0; b_clear_req = 0; b_rd_addr = 0; b_wr_addr = 0; b_wr_data = 0;
    tick();
    tick();
    check("reset_busy", {255'd0, busy}, 256'd1);
    check("reset_rd_data", {128'd0, rd_data}, 256'd0);
    reset = 0;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("busy_len_reset", 256'(n), 256'd32);
    for (int i = 0; i < 32; i += 2) begin
      rd_en = 1;
      rd_addr = {5'(i + 1), 5'(i)};
      tick();
      check("init_zero", {128'd0, rd_data}, 256'd0);
    end
    rd_en = 0;
    wr_en = 1; wr_addr = 9; wr_data = 64'hDEADBEEF;
    tick();
    wr_en = 0; rd_en = 1; rd_addr = {5'd0, 5'd9};
    tick();
    check("rd9_port0", {192'd0, rd_data[63:0]}, 256'hDEADBEEF);
    check("rd0_port1", {192'd0, rd_data[127:64]}, 256'd0);
    check("rd_valid_hi", {255'd0, rd_valid}, 256'd1);
    wr_en = 1; wr_addr = 21; wr_data = 64'h15; rd_addr = {5'd0, 5'd21};
    tick();
    check("bypass21", {192'd0, rd_data[63:0]}, 256'h15);
    wr_addr = 0; wr_data = 64'h5; rd_addr = {5'd0, 5'd0};
    tick();
    check("zero_bypass", {128'd0, rd_data}, 256'd0);
    wr_addr = 4; wr_data = 64'h77; rd_addr = {5'd4, 5'd9};
    tick();
    check("bypass_port1", {128'd0, rd_data}, {128'd0, 64'h77, 64'hDEADBEEF});
    wr_en = 0; rd_en = 0;
    tick();
    check("rd_valid_lo", {255'd0, rd_valid}, 256'd0);
    check("rd_hold", {128'd0, rd_data}, {128'd0, 64'h77, 64'hDEADBEEF});
    rd_en = 1; rd_addr = {5'd21, 5'd4};
    tick();
    check("stored_after_bypass", {128'd0, rd_data}, {128'd0, 64'h15, 64'h77});
    rd_en = 0;
    wr_en = 1; wr_addr = 12; wr_data = 64'h1234;
    tick();
    wr_en = 0; clear_req = 1;
    tick();
    clear_req = 0;
    check("clear_busy", {255'd0, busy}, 256'd1);
    for (int i = 0; i < 10; i++) begin
      clear_req = i == 3; rd_en = i == 3; wr_en = i == 3; wr_addr = 3; wr_data = 64'hAA;
      tick();
      check("busy_no_valid", {255'd0, rd_valid}, 256'd0);
    end
    clear_req = 0; rd_en = 0; wr_en = 0; reset = 1;
    tick();
    reset = 0;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("busy_len_midreset", 256'(n), 256'd32);
    rd_en = 1; rd_addr = {5'd3, 5'd12};
    tick();
    check("cleared12", {128'd0, rd_data}, 256'd0);
    rd_en = 0; clear_req = 1;
    tick();
    clear_req = 0;
    n = 0;
    while (busy && n < 100) begin clear_req = n == 5; tick(); n++; end
    clear_req = 0;
    check("busy_len_clearreq", 256'(n), 256'd32);
    wr_en = 1; wr_addr = 7; wr_data = 64'h99; clear_req = 1;
    tick();
    wr_en = 0; clear_req = 0;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("busy_len_clear_wr", 256'(n), 256'd32);
    rd_en = 1; rd_addr = {5'd7, 5'd7};
    tick();
    check("dropped7", {128'd0, rd_data}, 256'd0);
    rd_en = 0;
`ifdef REGFILE_PARITY_EN
    wr_en = 1; wr_addr = 10; wr_data = 64'hF0;
    tick();
    wr_en = 0;
    dut.mem[10][64] = ~dut.mem[10][64];
    flip_active = 1;
    rd_en = 1; rd_addr = {5'd0, 5'd10};
    tick();
    check("par_flag", {254'd0, par_err}, 256'd1);
    wr_en = 1; wr_data = 64'h3;
    tick();
    flip_active = 0;
    wr_en = 0; rd_en = 0;
    check("par_bypass", {254'd0, par_err}, 256'd0);
    check("par_bypass_data", {192'd0, rd_data[63:0]}, 256'h3);
`endif
    tick();
    b_reset = 0; b_wr_en = 1; b_wr_addr = 3; b_wr_data = 64'hAA;
    n = 0;
    while (b_busy && n < 100) begin tick(); b_wr_en = 0; n++; end
    check("b_busy_len", 256'(n), 256'd20);
    b_wr_en = 1; b_wr_addr = 25; b_wr_data = 64'h7;
    tick();
    b_wr_addr = 19; b_wr_data = 64'h55;
    tick();
    b_wr_en = 0; b_rd_en = 1; b_rd_addr = {5'd19, 5'd25, 5'd3};
    tick();
    check("b_range", {64'd0, b_rd_data}, {64'd0, 64'h55, 64'h0, 64'h0});
    check("b_valid", {255'd0, b_rd_valid}, 256'd1);
    b_wr_en = 1; b_wr_addr = 25; b_wr_data = 64'h9; b_rd_addr = {5'd25, 5'd19, 5'd25};
    tick();
    check("b_range_bypass", {64'd0, b_rd_data}, {64'd0, 64'h0, 64'h55, 64'h0});
    b_wr_addr = 19; b_wr_data = 64'h66; b_rd_addr = {5'd0, 5'd2, 5'd19};
    tick();
    check("b_bypass19", {64'd0, b_rd_data}, {64'd0, 64'h0, 64'h0, 64'h66});
    b_wr_en = 0; b_rd_en = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the team's single-clock integer register file.
- Provides NUM_RD registered read ports and one write port, with write-to-read bypass and an optional hardwired-zero entry 0.
- A clear sequencer zeroes every entry one per cycle after reset or on request.
- Sits between decode (read addresses) and writeback (write port) in the pipelined core.

Parameters:
- DATA_W, 64, width of each register in bits.
- DEPTH, 32, number of entries; any value from 2 to 256.
- NUM_RD, 2, number of read ports, from 1 to 4.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are dropped.
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- rd_en  in  1  read strobe; samples all read addresses this cycle.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, registered.
- rd_valid  out  1  rd_data holds the result of the previous accepted rd_en.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clear_req  in  1  pulse that requests a full clear.
- busy  out  1  clear sequencer active; accesses ignored.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: rd_data=0, rd_valid=0, busy=1, FSM=CLEAR, clear counter=0.
- FSM has two states, CLEAR and READY.
  - CLEAR: writes 0 to entry[counter] each cycle and increments the counter.
  - CLEAR exit: on the cycle counter==DEPTH-1 is written, the next state is READY, busy=0.
  - Busy duration: busy is high for exactly DEPTH cycles after reset deasserts.
  - READY to CLEAR: clear_req=1 in READY moves to CLEAR with counter=0; busy rises the next cycle.
  - clear_req while in CLEAR is ignored; it does not restart the sequence.
- Reset mid-CLEAR restarts the counter at 0. Reset in READY also enters CLEAR; array contents are discarded.
- While busy=1: wr_en and rd_en are ignored, rd_valid=0, rd_data holds its last value.
- Read latency is 1 cycle. rd_en=1 in READY at cycle N gives rd_data/rd_valid=1 at N+1.
- rd_en=0 gives rd_valid=0 next cycle; rd_data holds its value.
- Write: wr_en=1 in READY updates the entry at the clock edge.
- Bypass: same-cycle wr_en with wr_addr==rd_addr[k] returns wr_data on port k, not the stale value. Applies per port independently.
- Zero register (ZERO_REG=1): writes to address 0 are dropped; reads of address 0 return 0, including under bypass.
- Out-of-range addresses (>= DEPTH, non-power-of-2 DEPTH): reads return 0; writes are dropped.
- Simultaneous clear_req and wr_en in READY: the write is dropped and the clear begins.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from wr_data (or 0 during clear).
  - Reads recompute parity. Output port par_err (out, NUM_RD) is registered alongside rd_data; bit k=1 if port k mismatched.
  - Bypassed reads and address-0/out-of-range reads never flag.
  - par_err resets to 0 and is 0 whenever rd_valid=0.
- Undefined: no parity storage and no par_err port.

Decomposition:
- Package regfile_pkg holds:
  - state enum {CLEAR, READY};
  - default DATA_W/DEPTH constants;
  - a parity function.
- One sub-module, regfile_rd_port: per-port registered read mux with bypass, zero and range checks. It is instantiated NUM_RD times via generate; the clear FSM and array stay in the top.

Test Plan:
- Reset for 2 cycles, DEPTH=32 -> busy=1 for exactly 32 cycles after release; then reading all addresses returns 0.
- Write 0xDEAD_BEEF to 9; next cycle read rs=9 on port 0 and rs=0 on port 1 -> rd_data0=0xDEADBEEF, rd_data1=0, rd_valid=1.
- Same-cycle write 0x15 to 21 with rd_addr0=21 -> next cycle rd_data0=0x15 (bypass); write 5 to 0 with read 0 -> 0.
- Write 0x1234 to 12, pulse clear_req, then reassert reset at clear cycle 10 -> busy lasts 32 cycles from release; entry 12 reads 0.
- DEPTH=20, NUM_RD=3: write 0x7 to 25, read 25 -> 0; a write dropped while busy (addr 3, 0xAA) -> entry 3 reads 0.
- REGFILE_PARITY_EN: force-flip one stored bit of entry 10 via hierarchy, read 10 -> par_err[0]=1; bypassed read of 10 -> par_err=0.
